// File: rtl/data_mem_server.sv
// Shared data memory responder: round-robin arbitration across NPORT requesters,
// one access per cycle, reads return on a fixed two-stage pipeline.
package data_mem_pkg;
    typedef struct packed {
        logic [31:0] addr;  // word address
        logic [31:0] din;
        logic        we;    // 1 = write
    } data_in_t;
endpackage

module data_mem_server #(
    parameter int NPORT = 5,
    parameter int DEPTH = 131072,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NPORT-1:0]                  req_valid,
    input  data_mem_pkg::data_in_t [NPORT-1:0] req,
    output logic [NPORT-1:0]                  req_ready,
    output logic [NPORT-1:0]                  resp_valid,
    output logic [NPORT-1:0][31:0]            resp_data
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    // Handshake: a request transfers on the edge where req_valid[i] & req_ready[i];
    // the requester holds valid and payload stable until then. resp_valid is a
    // single-cycle pulse with no back-pressure.

    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          cand;
    logic [PW-1:0]          gnt_idx;
    logic                   gnt_vld;
    logic                   accept;
    logic                   rd_issue;
    data_mem_pkg::data_in_t gnt_req;
    logic [AW-1:0]          mem_idx;
    logic                   unused_addr_hi;

    logic                   s1_vld_q, s2_vld_q;
    logic [PW-1:0]          s1_port_q, s2_port_q;
    logic [31:0]            rd_q, dout_q;
    logic [31:0]            mem [DEPTH];

    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        cand      = ptr_q;
        req_ready = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
            cand = (cand == PW'(NPORT - 1)) ? '0 : cand + 1'b1;
        end
        if (rstn && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept         = rstn & gnt_vld;
    assign gnt_req        = req[gnt_idx];
    assign rd_issue       = accept & ~gnt_req.we;
    assign mem_idx        = gnt_req.addr[AW-1:0];
    assign unused_addr_hi = ^gnt_req.addr[31:AW];

    // Control path: pointer, pipeline valids and response registers are reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_port_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_port_q  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            if (gnt_vld) begin
                ptr_q <= (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
            end
            s1_vld_q   <= rd_issue;
            s1_port_q  <= gnt_idx;
            s2_vld_q   <= s1_vld_q;
            s2_port_q  <= s1_port_q;
            resp_valid <= '0;
            if (s2_vld_q) begin
                resp_valid[s2_port_q] <= 1'b1;
                resp_data[s2_port_q]  <= dout_q;
            end
        end
    end

    // BRAM array with registered read and output register; contents never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (gnt_req.we) begin
                mem[mem_idx] <= gnt_req.din;
            end else begin
                rd_q <= mem[mem_idx];
            end
        end
        dout_q <= rd_q;
    end
endmodule
